// File: rtl/ps2_scancode_decoder_if.sv
// Bus between the PS/2 receiver FIFO, the scan-code decoder and the
// logic that consumes decoded key events.
interface ps2_scancode_decoder_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_rdn;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [7:0] keys_down;
  logic       err;

  // master: receiver FIFO plus event consumer; slave: the decoder
  modport master (
    output kb_data, kb_ready, kb_overflow,
    input  kb_rdn, evt_valid, evt_code, evt_ext, evt_brk, keys_down, err
  );

  modport slave (
    input  kb_data, kb_ready, kb_overflow,
    output kb_rdn, evt_valid, evt_code, evt_ext, evt_brk, keys_down, err
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Pops Set-2 scan-code bytes from the receiver FIFO, strips E0/F0/E1 prefixes,
// emits one event per real key and tracks the held game-control keys.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic                  clk,
  input logic                  clr,
  ps2_scancode_decoder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

  state_t          state;
  logic [7:0]      byte_r;
  logic            ext_pend;
  logic            brk_pend;
  logic [2:0]      skip_cnt;
  logic [CW-1:0]   tmo_cnt;

  logic            tmo_run;
  logic            tmo_hit;
  logic [7:0]      mask;

  // Bit position in keys_down of a tracked key; zero for any other code.
  function automatic logic [7:0] key_mask(input logic [7:0] code, input logic ext);
    // NOTE: the default assignment up front keeps every path driven, so no latch.
    key_mask = 8'h00;
    if (ext) begin
      case (code)
        8'h75:   key_mask = 8'h01;
        8'h72:   key_mask = 8'h02;
        8'h6B:   key_mask = 8'h04;
        8'h74:   key_mask = 8'h08;
        default: key_mask = 8'h00;
      endcase
    end
    case (code)
      8'h29:   key_mask = 8'h10;
      8'h5A:   key_mask = ext ? 8'h00 : 8'h20;
      8'h76:   key_mask = 8'h40;
      8'h1D:   key_mask = 8'h80;
      default: ;
    endcase
  endfunction

  // Prefix state only ages while we are starved for the byte that completes it.
  assign tmo_run = (ext_pend || brk_pend || (skip_cnt != 3'd0)) &&
                   (state == IDLE) && !bus.kb_ready;
  assign tmo_hit = tmo_run && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mask    = key_mask(byte_r, ext_pend);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      byte_r        <= 8'h00;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      skip_cnt      <= 3'd0;
      tmo_cnt       <= '0;
      bus.kb_rdn    <= 1'b1;
      bus.evt_valid <= 1'b0;
      bus.evt_code  <= 8'h00;
      bus.evt_ext   <= 1'b0;
      bus.evt_brk   <= 1'b0;
      bus.keys_down <= 8'h00;
      bus.err       <= 1'b0;
    end else begin
      bus.evt_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.kb_ready) begin
            byte_r     <= bus.kb_data;
            bus.kb_rdn <= 1'b0;
            state      <= POP;
          end
        end
        POP: begin
          bus.kb_rdn <= 1'b1;
          state      <= DECODE;
        end
        DECODE: begin
          state <= IDLE;
          if (!bus.kb_overflow) begin
            if (skip_cnt != 3'd0) begin
              skip_cnt <= skip_cnt - 3'd1;
            end else if (byte_r == 8'hE1) begin
              // Pause: report once, swallow the remaining seven bytes.
              skip_cnt      <= 3'd7;
              bus.evt_valid <= 1'b1;
              bus.evt_code  <= 8'hE1;
              bus.evt_ext   <= 1'b0;
              bus.evt_brk   <= 1'b0;
              ext_pend      <= 1'b0;
              brk_pend      <= 1'b0;
            end else if (byte_r == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (byte_r == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (byte_r inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF} ||
                         (ext_pend && (byte_r == 8'h12 || byte_r == 8'h59))) begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end else begin
              bus.evt_valid <= 1'b1;
              bus.evt_code  <= byte_r;
              bus.evt_ext   <= ext_pend;
              bus.evt_brk   <= brk_pend;
              bus.keys_down <= brk_pend ? (bus.keys_down & ~mask) : (bus.keys_down | mask);
              ext_pend      <= 1'b0;
              brk_pend      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (tmo_hit) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        skip_cnt <= 3'd0;
        tmo_cnt  <= '0;
        bus.err  <= 1'b1;
      end else if (tmo_run) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      // Lost bytes make every held key and prefix suspect; start clean.
      if (bus.kb_overflow) begin
        bus.keys_down <= 8'h00;
        ext_pend      <= 1'b0;
        brk_pend      <= 1'b0;
        skip_cnt      <= 3'd0;
        tmo_cnt       <= '0;
        bus.err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: receiver FIFO model, constant vector table, randomized
// streams against a prefix-rule reference model, and timeout/overflow/reset sequences.
module tb_ps2_scancode_decoder;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo_q[$];
  logic [17:0] act_q[$];   // {code, ext, brk, keys_down}
  logic [17:0] exp_q[$];
  bit          rdn_was_low = 1'b0;
  int          pop_cnt = 0;

  // Reference model state
  logic       m_ext, m_brk;
  int         m_skip;
  logic [7:0] m_keys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    bus.kb_ready = (fifo_q.size() != 0);
    bus.kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // Receiver FIFO: advances its read pointer at the end of each kb_rdn-low cycle.
  always @(posedge clk) begin
    bit popped;
    popped = (bus.kb_rdn === 1'b0);
    #1;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    if (bus.evt_valid === 1'b1)
      act_q.push_back({bus.evt_code, bus.evt_ext, bus.evt_brk, bus.keys_down});
    if (bus.kb_rdn === 1'b0) begin
      pop_cnt++;
      check("rdn_single_cycle", 32'(rdn_was_low), 32'd0);
    end
    rdn_was_low = (bus.kb_rdn === 1'b0);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] key_code(input int k);
    case (k)
      0: return 8'h75;  1: return 8'h72;  2: return 8'h6B;  3: return 8'h74;
      4: return 8'h29;  5: return 8'h5A;  6: return 8'h76;  default: return 8'h1D;
    endcase
  endfunction

  function automatic int key_idx(input logic [7:0] c, input logic ext);
    for (int k = 0; k < 8; k++) begin
      if (key_code(k) == c) begin
        if (k < 4 && ext) return k;
        if (k == 5 && !ext) return k;
        if (k >= 4 && k != 5) return k;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_keys = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin
      m_skip = 7;
      exp_q.push_back({8'hE1, 2'b00, m_keys});
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF} ||
             (m_ext && (b == 8'h12 || b == 8'h59))) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      idx = key_idx(b, m_ext);
      if (idx >= 0) m_keys[idx] = !m_brk;
      exp_q.push_back({b, m_ext, m_brk, m_keys});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic emit(input logic [7:0] b);
    push_byte(b);
    model_byte(b);
  endtask

  // ---------------- helpers ----------------
  task automatic drain();
    int budget = 0;
    while (fifo_q.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL drain: fifo still holds %0d bytes, expected 0", fifo_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.kb_rdn !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL %s: kb_rdn never went low, expected a pop", tag);
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < act_q.size(); j++)
      check($sformatf("%s_evt%0d", tag, j), 32'(act_q[j]), 32'(exp_q[j]));
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_kb_rdn"},    32'(bus.kb_rdn),    32'd1);
    check({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'd0);
    check({tag, "_evt_code"},  32'(bus.evt_code),  32'h00);
    check({tag, "_evt_ext"},   32'(bus.evt_ext),   32'd0);
    check({tag, "_evt_brk"},   32'(bus.evt_brk),   32'd0);
    check({tag, "_keys_down"}, 32'(bus.keys_down), 32'h00);
    check({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          nb;
    logic [79:0] bytes;   // first byte in the most significant used position
    int          ne;
    logic [35:0] evts;    // first event in the most significant used position
    logic [7:0]  keys;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r, k;
    logic [7:0] other_codes[16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                    8'h46, 8'h45, 8'h15, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
    logic [7:0] junk_codes[6]   = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    vecs[0] = '{3, 80'h29F029, 2, {8'h29, 2'b00, 8'h10, 8'h29, 2'b01, 8'h00}, 8'h00};
    vecs[1] = '{5, 80'hE075E0F075, 2, {8'h75, 2'b10, 8'h01, 8'h75, 2'b11, 8'h00}, 8'h00};
    vecs[2] = '{3, 80'hE01229, 1, {18'd0, 8'h29, 2'b00, 8'h10}, 8'h10};
    vecs[3] = '{9, 80'hE11477E1F014F0775A, 2, {8'hE1, 2'b00, 8'h10, 8'h5A, 2'b00, 8'h30}, 8'h30};
    vecs[4] = '{4, 80'hF029F05A, 2, {8'h29, 2'b01, 8'h20, 8'h5A, 2'b01, 8'h00}, 8'h00};

    clr = 1'b1;
    bus.kb_overflow = 1'b0;
    refresh();
    model_reset();
    #2;
    check_reset("por");
    #20 clr = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      act_q.delete();
      pop_cnt = 0;
      for (int j = 0; j < vecs[i].nb; j++)
        push_byte(vecs[i].bytes[8*(vecs[i].nb-1-j) +: 8]);
      drain();
      check($sformatf("vec%0d_pops", i), 32'(pop_cnt), 32'(vecs[i].nb));
      check($sformatf("vec%0d_evt_count", i), 32'(act_q.size()), 32'(vecs[i].ne));
      for (int j = 0; j < vecs[i].ne && j < act_q.size(); j++)
        check($sformatf("vec%0d_evt%0d", i, j), 32'(act_q[j]),
              32'(vecs[i].evts[18*(vecs[i].ne-1-j) +: 18]));
      check($sformatf("vec%0d_keys", i), 32'(bus.keys_down), 32'(vecs[i].keys));
    end
    act_q.delete();

    // Latency: kb_ready sampled in cycle 0, pop in cycle 1, event in cycle 3
    push_byte(8'h1D);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lat_c%0d_evt_valid", c), 32'(bus.evt_valid), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("lat_c%0d_kb_rdn", c),    32'(bus.kb_rdn),    (c == 1) ? 32'd0 : 32'd1);
    end
    drain();
    exp_q.push_back({8'h1D, 2'b00, 8'h80});
    compare_events("lat");
    push_byte(8'hF0); push_byte(8'h1D);
    drain();
    exp_q.push_back({8'h1D, 2'b01, 8'h00});
    compare_events("lat_rel");

    // Randomized streams against the reference model
    model_reset();
    for (int round = 0; round < 4; round++) begin
      for (int t = 0; t < 30; t++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hE0);
            emit(b);
          end
          1: begin
            k = $urandom_range(0, 7);
            if (k < 4) emit(8'hE0);
            if ($urandom_range(0, 1) == 1) emit(8'hF0);
            emit(key_code(k));
          end
          2: emit(junk_codes[$urandom_range(0, 5)]);
          3: begin
            emit(8'hE0);
            if ($urandom_range(0, 1) == 1) emit(8'hF0);
            emit(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
          end
          4: begin
            emit(8'hE1); emit(8'h14); emit(8'h77); emit(8'hE1);
            emit(8'hF0); emit(8'h14); emit(8'hF0); emit(8'h77);
          end
          default: begin
            if ($urandom_range(0, 1) == 1) emit(8'hE0);
            if ($urandom_range(0, 1) == 1) emit(8'hF0);
            emit(other_codes[$urandom_range(0, 15)]);
          end
        endcase
      end
      while (m_ext || m_brk || m_skip != 0) emit(8'h16);
      drain();
      compare_events($sformatf("rnd%0d", round));
      check($sformatf("rnd%0d_keys", round), 32'(bus.keys_down), 32'(m_keys));
      check($sformatf("rnd%0d_err", round),  32'(bus.err),       32'd0);
    end

    // Release whatever the random streams left held
    for (int kk = 0; kk < 8; kk++) begin
      if (m_keys[kk]) begin
        if (kk < 4) emit(8'hE0);
        emit(8'hF0);
        emit(key_code(kk));
      end
    end
    drain();
    compare_events("release");
    check("release_keys", 32'(bus.keys_down), 32'h00);

    // Timeout: a lone E0 expires, the following 75 decodes unextended
    push_byte(8'hE0);
    repeat (3 + TMO - 2) @(posedge clk);
    #1;
    check("tmo_err_before", 32'(bus.err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("tmo_err_after", 32'(bus.err), 32'd1);
    model_reset();
    emit(8'h75);
    drain();
    compare_events("tmo");
    check("tmo_up_bit", 32'(bus.keys_down[0]), 32'd0);
    check("tmo_err_sticky", 32'(bus.err), 32'd1);

    // Reset pulse between scenarios
    #2 clr = 1'b1;
    #2;
    check_reset("clr1");
    @(posedge clk); #1 clr = 1'b0;
    model_reset();
    act_q.delete();

    // Overflow during DECODE: held keys dropped, byte dropped, err set
    emit(8'h29); emit(8'hE0); emit(8'h75);
    drain();
    compare_events("hold");
    check("hold_keys", 32'(bus.keys_down), 32'h11);
    push_byte(8'h5A);
    wait_pop("ovf_pop");
    @(posedge clk); #1;
    bus.kb_overflow = 1'b1;
    @(posedge clk); #1;
    bus.kb_overflow = 1'b0;
    check("ovf_keys", 32'(bus.keys_down), 32'h00);
    check("ovf_err",  32'(bus.err),       32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("ovf_no_event", 32'(act_q.size()), 32'd0);

    // clr asserted in the middle of a pop
    act_q.delete();
    push_byte(8'h29);
    wait_pop("clr_pop");
    #1 clr = 1'b1;
    #1;
    check_reset("clr_mid_pop");
    fifo_q.delete();
    refresh();
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("clr_no_event", 32'(act_q.size()), 32'd0);
    check("clr_keys", 32'(bus.keys_down), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumer stage directly downstream of the PS/2 keyboard receiver FIFO.
- Pops raw Set-2 scan-code bytes through the receiver's read strobe and strips E0 (extended), F0 (break) and E1 (Pause) prefixes.
- Emits one decoded key event per real key, discarding control bytes.
- Maintains a held-key bitmap for the game-control keys consumed by the top-level logic.

Parameters:
TIMEOUT_CYCLES, 2000000, clk cycles a pending prefix may wait for its next byte (20 ms at 100 MHz); counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  system clock, same domain as the keyboard receiver
clr  input  1  asynchronous, active-high reset
kb_data  input  8  receiver FIFO head byte, valid while kb_ready=1
kb_ready  input  1  receiver FIFO non-empty
kb_overflow  input  1  receiver FIFO overflow flag
kb_rdn  output  1  active-low pop strobe to the receiver, registered
evt_valid  output  1  one-cycle pulse, event fields valid
evt_code  output  8  scan code of the event, held until next event
evt_ext  output  1  event had an E0 prefix
evt_brk  output  1  1=release, 0=press/typematic repeat
keys_down  output  8  held keys: [0]Up E0-75 [1]Down E0-72 [2]Left E0-6B [3]Right E0-74 [4]Space 29 [5]Enter 5A (non-ext) [6]Esc 76 [7]W 1D
err  output  1  sticky error (timeout or overflow), cleared only by clr

Behaviour:
- Reset (async, clr=1):
  - Outputs: kb_rdn=1, evt_valid=0, evt_code=00, evt_ext=0, evt_brk=0, keys_down=00, err=0.
  - Internal: state=IDLE, ext_pend=0, brk_pend=0, skip_cnt=0, timeout counter=0.
  - clr asserted mid-pop forces kb_rdn=1 immediately; that byte may or may not have been popped, and no event is emitted for it.
- FSM IDLE -> POP -> DECODE -> IDLE, 3 cycles per byte:
  - IDLE: if kb_ready=1, capture byte_r<=kb_data, kb_rdn<=0, go to POP.
  - POP: kb_rdn is low for exactly this one cycle, so the receiver advances its read pointer at the end of it. Set kb_rdn<=1 and go to DECODE.
  - DECODE: process byte_r per the rules below, go to IDLE.
  - kb_ready is never sampled again until the cycle after kb_rdn returns high.
- Decode rules, first match wins:
  1. skip_cnt!=0: skip_cnt-1, no event.
  2. E1: skip_cnt<=7; emit event code E1, ext=0, brk=0; clear prefixes.
  3. E0: ext_pend<=1.
  4. F0: brk_pend<=1.
  5. FA, AA, EE, FE, 00, FF: discard, clear prefixes, no event.
  6. ext_pend=1 and code 12 or 59 (fake shift): discard, clear prefixes, no event.
  7. Otherwise: emit event {code, ext_pend, brk_pend}, clear prefixes.
- Event timing and bitmap:
  - evt_valid goes high in the cycle after DECODE, for one cycle. Latency is 3 cycles from kb_ready sampled to evt_valid.
  - The matching keys_down bit updates on the same edge as evt_valid: set on make, clear on break.
  - Make of an already-held key (typematic) re-emits the event; keys_down is unchanged.
  - Non-tracked codes leave keys_down unchanged.
- Timeout:
  - While any of ext_pend, brk_pend or skip_cnt!=0 is set and the FSM is in IDLE with kb_ready=0, the counter increments; otherwise it is 0.
  - At TIMEOUT_CYCLES: clear prefixes and skip_cnt, counter<=0, err<=1.
- Overflow:
  - kb_overflow=1 sampled in any cycle: at the next edge, keys_down<=00, prefixes and skip_cnt cleared, err<=1.
  - If the FSM is in DECODE in that cycle, the byte is dropped with no event.
  - A POP in progress completes normally.
  - Overflow takes precedence over a simultaneous decode.
- The receiver reset and clr are independent; garbage prefix state is bounded by the timeout.

Test Plan:
1. Byte stream 29, F0 29 -> events {29,ext0,brk0} then {29,ext0,brk1}; keys_down[4] 0->1->0; kb_rdn low exactly 1 cycle per byte, 3 pops total.
2. E0 75, then E0 F0 75 -> events {75,ext1,brk0}, {75,ext1,brk1}; keys_down[0] pulses; Space bit untouched.
3. E0 12, then 29 -> no event for 12; next event {29,ext0,brk0} (prefix cleared).
4. E1 14 77 E1 F0 14 F0 77, then 5A -> exactly two events: {E1,0,0} then {5A,0,0}; keys_down[5]=1.
5. TIMEOUT_CYCLES=16: E0, idle 16 cycles, then 75 -> err=1, event {75,ext0,brk0}, keys_down[0]=0.
6. Hold Space+Up (keys_down=11), one-cycle kb_overflow=1 -> next edge keys_down=00, err=1; then assert clr mid-POP -> kb_rdn=1 immediately, all outputs at reset values.
